div_issue_unit: RTL
===================

Name: div_issue_unit

Overview:
- Front-end stage directly upstream of the iterative divider core. Accepts RISC-V-style DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally, without using the core.
- Otherwise drives the core's valid/usigned/dividend/divisor inputs, holds them stable, and waits for the core's single-cycle res_ready pulse.
- Returns the selected quotient or remainder over a valid/ready response channel.

Parameters:
- parallelism, 32, operand/result width in bits
- TAG_W, 4, width of the request tag carried through to the response

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_dividend  in  parallelism  dividend
- req_divisor  in  parallelism  divisor
- req_tag  in  TAG_W  opaque tag
- flush  in  1  cancel the in-flight operation
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  parallelism  quotient or remainder
- resp_tag  out  TAG_W  tag of the request
- resp_bypass  out  1  result produced by special-case logic, not the core
- div_valid  out  1  start pulse to the divider core
- div_usigned  out  1  unsigned mode to the core
- div_dividend  out  parallelism  dividend to the core
- div_divisor  out  parallelism  divisor to the core
- div_quotient  in  parallelism  core quotient
- div_reminder  in  parallelism  core remainder
- div_res_ready  in  1  core result-valid pulse, one cycle

Behaviour:
- Reset state:
  - State IDLE.
  - Zero: all registers, resp_valid, resp_data, resp_tag, resp_bypass, div_valid, div_usigned, div_dividend, div_divisor.
  - req_ready=1 in IDLE, 0 in every other state.
- Accept: on req_valid&req_ready, register op, dividend, divisor and tag.
  - usigned = req_op[0].
  - want_rem = req_op[1].
- Special cases, evaluated on request inputs in the accept cycle:
  - divisor==0: quotient = all ones; remainder = dividend (signed and unsigned alike).
  - Signed op with dividend==MIN (1 followed by zeros) and divisor==all ones: quotient = MIN; remainder = 0.
  - When a special case hits: resp_data is loaded in the accept cycle, resp_bypass=1, next state RESP.
- States:
  - IDLE -> ISSUE on accept without a special case; IDLE -> RESP on accept with a special case.
  - ISSUE: div_valid=1 for exactly this one cycle; -> WAIT.
  - WAIT:
    - On div_res_ready, resp_data = want_rem ? div_reminder : div_quotient, resp_bypass=0.
    - Then -> RESP, or -> IDLE if the drop flag is set.
  - RESP: resp_valid=1 and resp_data/resp_tag held until resp_ready; on resp_valid&resp_ready -> IDLE.
- Operand stability: div_dividend, div_divisor and div_usigned are driven from registers. They stay constant from the ISSUE cycle through the div_res_ready cycle inclusive, because the core samples operand signs throughout.
- Latency:
  - Bypass: resp_valid rises in the cycle after accept (1 cycle).
  - Normal: core latency + 2 (ISSUE cycle, plus capture on res_ready edge).
- Back-to-back: after an accepted response the unit is in IDLE in the next cycle, so the minimum accept-to-accept interval for bypass ops is 2 cycles. The core has returned to its idle state before the next ISSUE.
- flush handling:
  - flush in ISSUE or WAIT sets the drop flag. The core cannot be aborted, so the unit still waits for div_res_ready, discards the result and returns to IDLE with no response.
  - flush in RESP clears resp_valid and returns to IDLE.
  - flush in IDLE has no effect.
  - flush coincident with accept: the request is still accepted.
- div_res_ready outside WAIT is ignored; it is a protocol error, flagged by an assertion.
- Reset asserted mid-operation returns the unit to IDLE immediately with all outputs zeroed. The core must be reset alongside, because it is left mid-division.
- resp_ready held high continuously is legal; the response completes in its first RESP cycle.

Decomposition:
- Package div_pkg holds:
  - op encoding enum (DIV, DIVU, REM, REMU)
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - localparams for the all-ones and MIN patterns as functions of parallelism
- One sub-module, div_special_detect: purely combinational. Inputs: op, dividend, divisor. Outputs: hit flag and the special-case quotient and remainder.
- FSM and registers stay in div_issue_unit.

Test Plan:
- DIVU 100/7, resp_ready=1 -> one div_valid pulse; core returns q=14 r=2; resp_data=14, resp_bypass=0, tag echoed.
- REM -100/7 signed -> div_usigned=0; resp_data=0xFFFFFFFE (-2); operands are stable on the core ports every cycle until div_res_ready.
- DIV 5/0 -> no div_valid; resp_valid in the next cycle with resp_data=0xFFFFFFFF, resp_bypass=1. REMU 5/0 -> resp_data=5.
- DIV 0x80000000/0xFFFFFFFF -> resp_data=0x80000000 with no div_valid. REM of the same operands -> resp_data=0.
- flush during WAIT -> no resp_valid; req_ready stays 0 until div_res_ready, and returns to 1 in the next cycle.
- resp_ready held low 5 cycles in RESP -> resp_data/resp_tag stable, req_ready=0; rst pulsed mid-WAIT -> all outputs 0 and req_ready=1 after release.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue stage.
package div_pkg;

  localparam int PARALLELISM = 32;

  // Bit patterns that select the special-case results at the default width.
  localparam logic [PARALLELISM-1:0] ALL_ONES = {PARALLELISM{1'b1}};
  localparam logic [PARALLELISM-1:0] MIN_VAL  = {1'b1, {(PARALLELISM-1){1'b0}}};

  // op[0] selects unsigned, op[1] selects remainder
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_special_detect.sv
// Combinational detection of divide-by-zero and signed overflow, with the
// architecturally defined quotient/remainder for those cases.
module div_special_detect
  import div_pkg::*;
#(
  parameter int parallelism = PARALLELISM
) (
  input  logic [1:0]             op_i,
  input  logic [parallelism-1:0] dividend_i,
  input  logic [parallelism-1:0] divisor_i,
  output logic                   hit_o,
  output logic [parallelism-1:0] quotient_o,
  output logic [parallelism-1:0] remainder_o
);

  localparam logic [parallelism-1:0] ONES  = {parallelism{1'b1}};
  localparam logic [parallelism-1:0] MIN_P = {1'b1, {(parallelism-1){1'b0}}};

  logic is_signed;
  logic div_zero;
  logic sgn_ovf;

  // Divide-by-zero takes priority; it also covers MIN / 0.
  always_comb begin
    is_signed   = (op_i == OP_DIV) || (op_i == OP_REM);
    div_zero    = (divisor_i == '0);
    sgn_ovf     = is_signed && (dividend_i == MIN_P) && (divisor_i == ONES);
    hit_o       = div_zero || sgn_ovf;
    quotient_o  = div_zero ? ONES : MIN_P;
    remainder_o = div_zero ? dividend_i : '0;
  end

endmodule

// File: rtl/div_issue_unit.sv
// Issue stage in front of the iterative divider core. Special cases are
// answered locally; everything else is handed to the core with operands held
// stable from registers until the core's result pulse.
//
// state   | meaning
// IDLE    | ready for a new request
// ISSUE   | one-cycle start pulse to the core
// WAIT    | core busy; waiting for div_res_ready (result dropped if flushed)
// RESP    | response held on resp_* until resp_ready or flush
module div_issue_unit
  import div_pkg::*;
#(
  parameter int parallelism = PARALLELISM,
  parameter int TAG_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [parallelism-1:0] req_dividend,
  input  logic [parallelism-1:0] req_divisor,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic                   flush,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [parallelism-1:0] resp_data,
  output logic [TAG_W-1:0]       resp_tag,
  output logic                   resp_bypass,
  output logic                   div_valid,
  output logic                   div_usigned,
  output logic [parallelism-1:0] div_dividend,
  output logic [parallelism-1:0] div_divisor,
  input  logic [parallelism-1:0] div_quotient,
  input  logic [parallelism-1:0] div_reminder,
  input  logic                   div_res_ready
);

  div_state_e state_q, state_d;

  logic [1:0]             op_q, op_d;
  logic [parallelism-1:0] dividend_q, dividend_d;
  logic [parallelism-1:0] divisor_q, divisor_d;
  logic [parallelism-1:0] data_q, data_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic                   bypass_q, bypass_d;
  logic                   drop_q, drop_d;

  logic                   accept;
  logic                   drop_now;
  logic                   sp_hit;
  logic [parallelism-1:0] sp_quo;
  logic [parallelism-1:0] sp_rem;

  assign accept   = req_valid && (state_q == S_IDLE);
  // A flush arriving in the same cycle as the result still discards it.
  assign drop_now = drop_q || flush;

  div_special_detect #(
    .parallelism(parallelism)
  ) u_detect (
    .op_i       (req_op),
    .dividend_i (req_dividend),
    .divisor_i  (req_divisor),
    .hit_o      (sp_hit),
    .quotient_o (sp_quo),
    .remainder_o(sp_rem)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the core cannot be aborted so a flushed op still waits for its result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = sp_hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (div_res_ready) state_d = drop_now ? S_IDLE : S_RESP;
      S_RESP:  if (flush || resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    div_valid  = (state_q == S_ISSUE);
    resp_valid = (state_q == S_RESP);
  end

  // Datapath next-state: operands only change on accept, i.e. never while the core is busy.
  always_comb begin
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    data_d     = data_q;
    tag_d      = tag_q;
    bypass_d   = bypass_q;
    drop_d     = drop_q;
    if (accept) begin
      op_d       = req_op;
      dividend_d = req_dividend;
      divisor_d  = req_divisor;
      tag_d      = req_tag;
      drop_d     = 1'b0;
      bypass_d   = sp_hit;
      if (sp_hit) data_d = req_op[1] ? sp_rem : sp_quo;
    end
    if ((state_q == S_ISSUE || state_q == S_WAIT) && flush) drop_d = 1'b1;
    if (state_q == S_WAIT && div_res_ready && !drop_now) begin
      data_d   = op_q[1] ? div_reminder : div_quotient;
      bypass_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      bypass_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      bypass_q   <= bypass_d;
      drop_q     <= drop_d;
    end
  end

  // Core operands come straight from registers so they cannot move while the core samples signs.
  always_comb begin
    div_usigned  = op_q[0];
    div_dividend = dividend_q;
    div_divisor  = divisor_q;
    resp_data    = data_q;
    resp_tag     = tag_q;
    resp_bypass  = bypass_q;
  end

`ifndef SYNTHESIS
  // A result pulse outside WAIT means the core and this unit disagree on who owns an operation.
  res_ready_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    div_res_ready |-> (state_q == S_WAIT))
    else $error("div_res_ready pulsed outside WAIT");
`endif

endmodule
